// File: rtl/modn_updown_counter_pkg.sv
// Shared constants and the width helper for the mod-N up/down counter.
// Direction and bound-mode encodings match the A and MODE pin polarities.
package modn_updown_counter_pkg;
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Counter width for a given modulus; never narrower than one bit.
    function automatic int modn_width(input int m);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction
endpackage

// File: rtl/modn_step.sv
// Next-count and bound decode for one mod-N step; purely combinational.
// Out-of-range counts steer to zero and never report a bound.
module modn_step
    import modn_updown_counter_pkg::*;
#(
    parameter  int MOD = 10,
    localparam int W   = modn_width(MOD)
) (
    input  logic [W-1:0] i_q,
    input  logic         i_a,
    input  logic         i_mode,
    output logic [W-1:0] o_q_nxt,
    output logic         o_at_bound
);
    localparam logic [W-1:0] MAXV = W'(MOD - 1);
    localparam logic [W:0]   MODV = (W+1)'(MOD);

    logic w_out_of_range;
    assign w_out_of_range = ({1'b0, i_q} >= MODV);

    always_comb begin
        o_q_nxt    = '0;
        o_at_bound = 1'b0;
        if (!w_out_of_range) begin
            unique case (i_a)
                DIR_UP: begin
                    o_at_bound = (i_q == MAXV);
                    if (o_at_bound)
                        o_q_nxt = (i_mode == MODE_WRAP) ? '0 : MAXV;
                    else
                        o_q_nxt = i_q + W'(1);
                end
                DIR_DN: begin
                    o_at_bound = (i_q == '0);
                    if (o_at_bound)
                        o_q_nxt = (i_mode == MODE_SAT) ? '0 : MAXV;
                    else
                        o_q_nxt = i_q - W'(1);
                end
            endcase
        end
    end
endmodule

// File: rtl/modn_updown_counter.sv
// Mod-N up/down counter with load, wrap/saturate and cascadable terminal count.
// Q and LERR are registered (1-cycle); TC is combinational for TC->EN chaining.
module modn_updown_counter
    import modn_updown_counter_pkg::*;
#(
    parameter  int MOD = 10,
    localparam int W   = modn_width(MOD)
) (
    input  logic         CLK,
    input  logic         R,
    input  logic         EN,
    input  logic         A,
    input  logic         MODE,
    input  logic         LD,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q,
    output logic         Y,
    output logic         TC,
    output logic         LERR
);
    localparam logic [W:0] MODV = (W+1)'(MOD);

    logic [W-1:0] r_q;
    logic         r_lerr;
    logic [W-1:0] w_q_nxt;
    logic         w_at_bound;
    logic         w_ld_err;
    logic         w_q_bad;

    modn_step #(.MOD(MOD)) u_step (
        .i_q        (r_q),
        .i_a        (A),
        .i_mode     (MODE),
        .o_q_nxt    (w_q_nxt),
        .o_at_bound (w_at_bound)
    );

    assign w_ld_err = ({1'b0, D}   >= MODV);
    assign w_q_bad  = ({1'b0, r_q} >= MODV);

    // A corrupted count is scrubbed even while EN is low.
    always_ff @(posedge CLK) begin
        if (R) begin
            r_q    <= '0;
            r_lerr <= 1'b0;
        end else if (LD) begin
            r_q    <= w_ld_err ? '0 : D;
            r_lerr <= w_ld_err;
        end else begin
            r_lerr <= 1'b0;
            if (EN || w_q_bad)
                r_q <= w_q_nxt;
        end
    end

    assign Q    = r_q;
    assign Y    = (r_q == '0);
    assign LERR = r_lerr;
    assign TC   = ~R & ~LD & EN & w_at_bound;
endmodule
